// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way cache controller: geometry defaults, FSM codes, address split.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package cache_pkg;

   localparam int CACHE_IDX_W  = 4;
   localparam int CACHE_WOFF_W = 2;
   localparam int CACHE_TAG_W  = 32 - 2 - CACHE_WOFF_W - CACHE_IDX_W;

   // FSM encoding kept as plain constants so older flows can consume it
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_LOOKUP    = 2'd1;
   localparam state_t ST_WRITEBACK = 2'd2;
   localparam state_t ST_REFILL    = 2'd3;

   // Address split {tag, index, word, 2'b00} for the default geometry
   function automatic logic [CACHE_TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[31 -: CACHE_TAG_W];
   endfunction

   function automatic logic [CACHE_IDX_W-1:0] addr_idx(input logic [31:0] addr);
      return addr[2+CACHE_WOFF_W +: CACHE_IDX_W];
   endfunction

   function automatic logic [CACHE_WOFF_W-1:0] addr_word(input logic [31:0] addr);
      return addr[2 +: CACHE_WOFF_W];
   endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Per-way tag/valid/dirty arrays and per-set LRU bit for a 2-way cache.
// Latency: lookup is combinational on idx; updates land on the next clk edge.
// Backpressure: none; the controller serialises all updates.
module cache_tag_store
   import cache_pkg::*;
#(
   parameter int IDX_W = CACHE_IDX_W,
   parameter int TAG_W = CACHE_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] idx,
   output logic [TAG_W-1:0] tag0,
   output logic [TAG_W-1:0] tag1,
   output logic [1:0]       valid,
   output logic [1:0]       dirty,
   output logic             lru,
   input  logic             upd_way,
   input  logic             inval,
   input  logic             fill,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic             dirty_set,
   input  logic             dirty_clr,
   input  logic             lru_wr,
   input  logic             lru_val
);

   localparam int SETS = 2**IDX_W;

   logic [1:0][TAG_W-1:0] tag_mem   [SETS];
   logic [1:0]            valid_mem [SETS];
   logic [1:0]            dirty_mem [SETS];
   logic [SETS-1:0]       lru_mem;

   assign tag0  = tag_mem[idx][0];
   assign tag1  = tag_mem[idx][1];
   assign valid = valid_mem[idx];
   assign dirty = dirty_mem[idx];
   assign lru   = lru_mem[idx];

   // Array updates; a fill installs the line clean, otherwise invalidate/dirty edits apply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            tag_mem[s]   <= '0;
            valid_mem[s] <= '0;
            dirty_mem[s] <= '0;
         end
         lru_mem <= '0;
      end else begin
         if (fill) begin
            tag_mem[idx][upd_way]   <= fill_tag;
            valid_mem[idx][upd_way] <= 1'b1;
            dirty_mem[idx][upd_way] <= 1'b0;
         end else begin
            if (inval)
               valid_mem[idx][upd_way] <= 1'b0;
            if (dirty_set)
               dirty_mem[idx][upd_way] <= 1'b1;
            else if (dirty_clr)
               dirty_mem[idx][upd_way] <= 1'b0;
         end
         if (lru_wr)
            lru_mem[idx] <= lru_val;
      end
   end

endmodule

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative cache control FSM: lookup, dirty writeback, refill; CACHE_STATS_EN adds hit/miss counters.
// Latency: hit answers one cycle after cpu_req is sampled; misses add a WORDS-beat refill (plus writeback if dirty) and a re-lookup.
// Backpressure: cpu_req held until cpu_ready; memory stalls by withholding mem_ack while mem_req stays high.
module cache_ctrl_2way
   import cache_pkg::*;
#(
   parameter int IDX_W  = CACHE_IDX_W,
   parameter int WOFF_W = CACHE_WOFF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   output logic              cpu_ready,
   output logic              cpu_hit,
   output logic              da_way,
   output logic [IDX_W-1:0]  da_index,
   output logic [WOFF_W-1:0] da_word,
   output logic              da_we,
   output logic              da_src,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int TAG_W = 32 - 2 - WOFF_W - IDX_W;

   state_t            state;
   logic              req_we;
   logic [29:0]       req_line;
   logic              miss_flag;
   logic              victim;
   logic [WOFF_W-1:0] cnt;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WOFF_W-1:0] req_word;
   logic [TAG_W-1:0]  tag0, tag1, vict_tag;
   logic [1:0]        valid, dirty;
   logic              lru;
   logic              hit0, hit1, hit, hit_way, vict_pick, last;
   logic              upd_way, inval, fill, dirty_set, dirty_clr, lru_wr, lru_val;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = ^cpu_addr[1:0];

   assign req_tag  = req_line[29 -: TAG_W];
   assign req_idx  = req_line[WOFF_W +: IDX_W];
   assign req_word = req_line[WOFF_W-1:0];

   assign hit0      = valid[0] && (tag0 == req_tag);
   assign hit1      = valid[1] && (tag1 == req_tag);
   assign hit       = hit0 || hit1;
   assign hit_way   = ~hit0;
   assign vict_pick = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);
   assign vict_tag  = victim ? tag1 : tag0;
   assign last      = (cnt == {WOFF_W{1'b1}});

   cache_tag_store #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (req_idx),
      .tag0      (tag0),
      .tag1      (tag1),
      .valid     (valid),
      .dirty     (dirty),
      .lru       (lru),
      .upd_way   (upd_way),
      .inval     (inval),
      .fill      (fill),
      .fill_tag  (req_tag),
      .dirty_set (dirty_set),
      .dirty_clr (dirty_clr),
      .lru_wr    (lru_wr),
      .lru_val   (lru_val)
   );

   // Outputs and tag-store strobes decoded from the current state; all zero in IDLE
   always_comb begin
      cpu_ready = 1'b0;
      cpu_hit   = 1'b0;
      da_way    = 1'b0;
      da_index  = '0;
      da_word   = '0;
      da_we     = 1'b0;
      da_src    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      upd_way   = 1'b0;
      inval     = 1'b0;
      fill      = 1'b0;
      dirty_set = 1'b0;
      dirty_clr = 1'b0;
      lru_wr    = 1'b0;
      lru_val   = 1'b0;
      case (state)
         ST_LOOKUP: begin
            if (hit) begin
               cpu_ready = 1'b1;
               cpu_hit   = ~miss_flag;
               da_way    = hit_way;
               da_index  = req_idx;
               da_word   = req_word;
               da_we     = req_we;
               upd_way   = hit_way;
               dirty_set = req_we;
               lru_wr    = 1'b1;
               lru_val   = ~hit_way;
            end
         end
         ST_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vict_tag, req_idx, cnt, 2'b00};
            da_way    = victim;
            da_index  = req_idx;
            da_word   = cnt;
            upd_way   = victim;
            dirty_clr = mem_ack && last;
         end
         ST_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, cnt, 2'b00};
            da_way   = victim;
            da_index = req_idx;
            da_word  = cnt;
            da_we    = mem_ack;
            da_src   = mem_ack;
            upd_way  = victim;
            fill     = mem_ack && last;
            inval    = !(mem_ack && last);
         end
         default: ;
      endcase
   end

   // Request capture, miss bookkeeping and burst word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_we    <= 1'b0;
         req_line  <= '0;
         miss_flag <= 1'b0;
         victim    <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  req_we    <= cpu_we;
                  req_line  <= cpu_addr[31:2];
                  miss_flag <= 1'b0;
                  state     <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (hit) begin
                  state <= ST_IDLE;
               end else begin
                  miss_flag <= 1'b1;
                  victim    <= vict_pick;
                  cnt       <= '0;
                  state     <= (valid[vict_pick] && dirty[vict_pick]) ? ST_WRITEBACK : ST_REFILL;
               end
            end
            ST_WRITEBACK: begin
               if (mem_ack) begin
                  cnt <= cnt + 1'b1;
                  if (last)
                     state <= ST_REFILL;
               end
            end
            default: begin
               if (mem_ack) begin
                  cnt <= cnt + 1'b1;
                  if (last)
                     state <= ST_LOOKUP;
               end
            end
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   // Completion counters, free-running with natural 32-bit wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (cpu_ready) begin
         if (cpu_hit)
            hit_cnt <= hit_cnt + 32'd1;
         else
            miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/cache_ctrl_2way.md
# cache_ctrl_2way

Control FSM for the 2-way set-associative cache: accepts one CPU load/store at a time, compares tags in both ways, updates valid/dirty/LRU state, and sequences dirty-victim writeback and line refill against the memory port. It owns the tag/valid/dirty/LRU arrays. It only steers the external data array through way/index/word/write-enable controls, and carries no data itself.

## Interface
- IDX_W, 4: set-index bits; SETS = 2**IDX_W.
- WOFF_W, 2: word-offset bits; WORDS = 2**WOFF_W per line.
- TAG_W, 32-2-WOFF_W-IDX_W: tag bits. Address split is {tag, index, word, 2'b00}.
- Clock and reset: one clock. Reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request. Held high until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load. Sampled with cpu_req.
- cpu_addr  in  32  byte address. Sampled with cpu_req.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  valid with cpu_ready. 1 = request hit on first lookup.
- da_way  out  1  data-array way select.
- da_index  out  IDX_W  data-array set select.
- da_word  out  WOFF_W  data-array word select.
- da_we  out  1  data-array write strobe.
- da_src  out  1  write source: 0 = CPU store data, 1 = memory read data.
- mem_req  out  1  memory word request.
- mem_we  out  1  1 = writeback word, 0 = refill word.
- mem_addr  out  32  word-aligned memory address.
- mem_ack  in  1  one word transferred this cycle.

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL.
- IDLE
  - cpu_req=1 latches we/addr and clears miss flag -> LOOKUP.
- LOOKUP
  - hit(w) = valid[w][idx] && tag[w][idx]==req_tag. Way 0 wins if both ways hit (cannot occur legally).
  - Hit: da_way=w, da_word=req word. Store: da_we=1, da_src=0, dirty[w][idx]=1. lru[idx]=~w. cpu_ready=1, cpu_hit=~miss_flag -> IDLE.
  - Miss: set miss_flag and pick victim v = first invalid way (way 0 first), else lru[idx]. valid&&dirty -> WRITEBACK, else -> REFILL. Word counter cleared.
- WRITEBACK
  - mem_req=1, mem_we=1, mem_addr={tag[v],idx,cnt,2'b00}, da_way=v, da_word=cnt.
  - Each mem_ack increments cnt.
  - Ack at cnt=WORDS-1: dirty[v]=0, cnt wraps to 0 -> REFILL.
- REFILL
  - mem_req=1, mem_we=0, mem_addr={req_tag,idx,cnt,2'b00}.
  - Each mem_ack: da_we=1, da_src=1, da_way=v, da_word=cnt, cnt++.
  - valid[v]=0 while refilling.
  - Last ack: tag[v]=req_tag, valid=1, dirty=0 -> LOOKUP. Re-lookup hits, and a store miss completes as write-allocate.
- mem_ack outside WRITEBACK/REFILL is ignored. cpu_req outside IDLE is not re-sampled.
- Reset: state IDLE; all valid/dirty/lru cleared; cnt=0; every output 0. Reset mid-burst aborts immediately with no partial-line valid.

## Timing
- Hit latency: cpu_req seen at edge N, cpu_ready high during cycle N+1 (registered state, combinational outputs).
- Clean miss: 1 (lookup) + WORDS ack cycles (minimum) + 1 (re-lookup).
- Dirty miss adds WORDS ack cycles of writeback.
- Back-to-back requests: cpu_req still high in the cpu_ready cycle is not a new request. The next request is accepted in IDLE one cycle later, so minimum 2 cycles per hit.
- mem_req stays high continuously across a burst. The memory may stall arbitrarily by withholding mem_ack.

## Configuration
- CACHE_STATS_EN defined: adds outputs hit_cnt and miss_cnt (32 bits each).
  - Each increments on cpu_ready according to cpu_hit.
  - Both wrap at 2**32 and reset to 0.
- CACHE_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- cache_pkg holds:
  - the state enum;
  - default IDX_W/WOFF_W and the derived TAG_W;
  - helper functions splitting an address into tag/index/word.
- Sub-module cache_tag_store: per-way tag/valid/dirty arrays plus per-set LRU bit, with lookup and update ports and async clear on rst_n. The FSM stays in cache_ctrl_2way.

## Test plan
- After reset, load 0x0000_0100: miss. REFILL issues mem_addr 0x100, 0x104, 0x108, 0x10C with da_src=1. Then cpu_ready with cpu_hit=0, and set 0 way 0 becomes valid.
- Repeat load 0x0000_0104: cpu_ready one cycle after request, cpu_hit=1, no mem_req.
- Store 0x0000_0108 (hit), then load 0x0001_0100 and 0x0002_0100, which map to the same set.
  - Second miss evicts way 0 (LRU).
  - Expect WRITEBACK mem_we=1 at 0x100..0x10C before the refill from 0x0002_0100.
- Hold mem_ack low 5 cycles mid-refill: mem_req stays high, cnt holds, no da_we.
- Assert rst_n=0 during the third refill word: outputs go 0 at once. The following load to the same address misses.
- CACHE_STATS_EN: run the above sequence; check hit_cnt and miss_cnt against the cpu_hit values recorded at each cpu_ready.
